// File: rtl/rle_pack_compressor.sv
// rle_pack_compressor: zero-run-length packer, GROUPS (run,val)
// groups per word, double-buffered accumulator and output register.
module rle_pack_compressor #(
  parameter int LANES  = 16,
  parameter int DATA_W = 8,
  parameter int RUN_W  = 4,
  parameter int GROUPS = 5,
  parameter int CNT_W  = $clog2(GROUPS+1),
  parameter int OUT_W  = GROUPS*(RUN_W+DATA_W)+CNT_W+1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [LANES*DATA_W-1:0]    in_data,
  input  logic [$clog2(LANES+1)-1:0] in_count,
  input  logic                       in_last,
  output logic [$clog2(LANES+1)-1:0] in_taken,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  input  logic                       out_ready,
  output logic [31:0]                words_out
);

  localparam int IC_W = $clog2(LANES+1);
  localparam int GW   = RUN_W + DATA_W;
  localparam int GB   = GROUPS * GW;
  localparam logic [RUN_W-1:0] RMAX = '1;
  localparam logic [CNT_W-1:0] GMAX = CNT_W'(GROUPS);

  typedef enum logic {ACC, STALL} state_t;

  state_t state, state_nx;

  logic [GB-1:0]    acc_grp, nx_grp;
  logic [CNT_W-1:0] acc_cnt, nx_cnt;
  logic [RUN_W-1:0] acc_run, nx_run;
  logic [OUT_W-1:0] hold_data, word;
  logic [IC_W-1:0]  taken;
  logic [DATA_W-1:0] e;
  logic full, tail, flush, close;
  logic out_free, load_acc, hold_en, load_hold;

  assign out_free = !out_valid || out_ready;

  // Encode this beat's lanes on top of the accumulator, stopping at a full word
  always_comb begin
    nx_grp = acc_grp;
    nx_cnt = acc_cnt;
    nx_run = acc_run;
    taken  = '0;
    full   = 1'b0;
    tail   = 1'b0;
    flush  = 1'b0;
    close  = 1'b0;
    e      = '0;
    if (state == ACC && in_valid && !clear) begin
      for (int i = 0; i < LANES; i++) begin
        if (i < int'(in_count) && !full) begin
          e = in_data[i*DATA_W +: DATA_W];
          taken = taken + 1'b1;
          if (e == '0 && nx_run != RMAX) begin
            nx_run = nx_run + 1'b1;
          end else begin
            nx_grp[int'(nx_cnt)*GW +: GW] = {e, nx_run};
            nx_cnt = nx_cnt + 1'b1;
            nx_run = '0;
            full   = (nx_cnt == GMAX);
          end
        end
      end
      flush = in_last && (taken == in_count);
      if (flush && !full && nx_run != '0) begin
        nx_grp[int'(nx_cnt)*GW +: GW] = {{DATA_W{1'b0}}, nx_run};
        nx_cnt = nx_cnt + 1'b1;
        nx_run = '0;
        tail   = 1'b1;
      end
      close = full || (flush && nx_cnt != '0);
    end
  end

  assign word = {nx_cnt, tail, nx_grp};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nx;
  end

  // Next state: park a closed word while the output register is busy
  always_comb begin
    state_nx = state;
    unique case (state)
      ACC:   if (!clear && close && !out_free) state_nx = STALL;
      STALL: if (clear || out_free) state_nx = ACC;
    endcase
  end

  // Output decode: lane handshake and word routing
  always_comb begin
    in_taken  = rst_n ? taken : '0;
    load_acc  = close && out_free;
    hold_en   = close && !out_free;
    load_hold = (state == STALL) && !clear && out_free;
  end

  // Accumulator update; a closed word restarts the group list
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_grp <= '0;
      acc_cnt <= '0;
      acc_run <= '0;
    end else if (clear) begin
      acc_grp <= '0;
      acc_cnt <= '0;
      acc_run <= '0;
    end else if (close) begin
      acc_grp <= '0;
      acc_cnt <= '0;
      acc_run <= nx_run;
    end else begin
      acc_grp <= nx_grp;
      acc_cnt <= nx_cnt;
      acc_run <= nx_run;
    end
  end

  // Second buffer for a word closed while the output is blocked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       hold_data <= '0;
    else if (hold_en) hold_data <= word;
  end

  // Output register and accepted-word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      words_out <= '0;
    end else begin
      if (out_valid && out_ready) words_out <= words_out + 32'd1;
      if (load_acc) begin
        out_valid <= 1'b1;
        out_data  <= word;
      end else if (load_hold) begin
        out_valid <= 1'b1;
        out_data  <= hold_data;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rle_pack_compressor.sv
// tb_rle_pack_compressor: directed cases plus randomized segments
// checked against a segment-level encoding model.
module tb_rle_pack_compressor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic [127:0] in_data;
  logic [4:0]   in_count;
  logic         in_last;
  logic [4:0]   in_taken;
  logic         out_valid;
  logic [63:0]  out_data;
  logic         out_ready;
  logic [31:0]  words_out;

  logic dir_ready = 1'b1;
  logic rnd_ready = 1'b1;
  logic mon_en = 1'b0;
  logic prev_hold = 1'b0;
  logic [63:0] prev_data = '0;

  int checks = 0;
  int failures = 0;
  logic [63:0] expq[$];
  int n_model = 0;

  assign out_ready = mon_en ? rnd_ready : dir_ready;

  always #5 clk = ~clk;

  rle_pack_compressor dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data),
    .in_count(in_count), .in_last(in_last),
    .in_taken(in_taken), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready),
    .words_out(words_out)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [59:0] g(input int k, input int run,
                                    input int val);
    logic [59:0] r;
    r = '0;
    r[k*12 +: 12] = {val[7:0], run[3:0]};
    return r;
  endfunction

  function automatic logic [63:0] mkw(input int cnt, input bit tl,
                                      input logic [59:0] grp);
    return {cnt[2:0], tl, grp};
  endfunction

  // Encode a whole flushed segment, then chunk its groups into words
  function automatic void model_seg(input int s[$]);
    int run;
    int gq[$];
    int n;
    bit tl;
    logic [59:0] w;
    run = 0;
    foreach (s[i]) begin
      if (s[i] == 0 && run < 15) run++;
      else begin
        gq.push_back(run*256 + s[i]);
        run = 0;
      end
    end
    while (gq.size() >= 5) begin
      w = '0;
      for (int k = 0; k < 5; k++) w |= g(k, gq[k]/256, gq[k]%256);
      for (int k = 0; k < 5; k++) void'(gq.pop_front());
      expq.push_back(mkw(5, 1'b0, w));
      n_model++;
    end
    if (gq.size() > 0 || run > 0) begin
      tl = 1'b0;
      if (run > 0) begin
        gq.push_back(run*256);
        tl = 1'b1;
      end
      w = '0;
      n = gq.size();
      for (int k = 0; k < n; k++) w |= g(k, gq[k]/256, gq[k]%256);
      expq.push_back(mkw(n, tl, w));
      n_model++;
    end
  endfunction

  // Called at a negedge; leaves at the next negedge with in_valid low
  task automatic step(input logic [127:0] d, input int cnt,
                      input bit lst, input int exp_tk, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    in_count = 5'(cnt);
    in_last  = lst;
    #1;
    chk(tag, 64'(in_taken), 64'(exp_tk));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Random-phase output side: random ready, word and stability checks
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_hold) begin
        chk("hold_stable", out_data, prev_data);
        chk("hold_valid", 64'(out_valid), 64'd1);
      end
      rnd_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && rnd_ready) begin
        if (expq.size() == 0) chk("unexpected_word", out_data, 64'd0);
        else chk("rand_word", out_data, expq.pop_front());
      end
      prev_hold = out_valid && !rnd_ready;
      prev_data = out_data;
    end
  end

  logic [59:0] wa, wb, w5;
  int seg[$];
  int len, p, cnt, tk, budget, base;
  bit done, vld, lst;

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b1;
    in_data = {4{$urandom}};
    in_count = 5'd16;
    in_last = 1'b1;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_words_out", 64'(words_out), 64'd0);
    chk("rst_in_taken", 64'(in_taken), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);

    // five nonzeros close a word mid-beat
    step(128'h372C21160B, 16, 0, 5, "t1_taken");
    w5 = g(0,0,11) | g(1,0,22) | g(2,0,33) | g(3,0,44) | g(4,0,55);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_word", out_data, mkw(5, 0, w5));
    @(negedge clk);
    chk("t1_words_out", 64'(words_out), 64'd1);

    // run saturation across beats
    step(128'h0, 16, 0, 16, "t2_taken_a");
    chk("t2_no_word", 64'(out_valid), 64'd0);
    step(128'h0900000000, 5, 1, 5, "t2_taken_b");
    chk("t2_word", out_data, mkw(2, 0, g(0,15,0) | g(1,4,9)));
    @(negedge clk);

    // tail-only flush
    step(128'h0, 3, 1, 3, "t3_taken");
    chk("t3_word", out_data, mkw(1, 1, g(0,3,0)));
    @(negedge clk);
    chk("t3_words_out", 64'(words_out), 64'd3);

    // backpressure: second word parks, input stalls
    dir_ready = 1'b0;
    wa = g(0,0,1) | g(1,0,2) | g(2,0,3) | g(3,0,4) | g(4,0,5);
    wb = g(0,0,6) | g(1,0,7) | g(2,0,8) | g(3,0,9) | g(4,0,10);
    step(128'h0504030201, 5, 0, 5, "t4_taken_a");
    step(128'h0A09080706, 5, 0, 5, "t4_taken_b");
    in_valid = 1'b1;
    in_data  = 128'h0B;
    in_count = 5'd1;
    #1;
    chk("t4_stall_taken", 64'(in_taken), 64'd0);
    chk("t4_word_a", out_data, mkw(5, 0, wa));
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_stable", out_data, mkw(5, 0, wa));
    dir_ready = 1'b1;
    @(negedge clk);
    chk("t4_word_b", out_data, mkw(5, 0, wb));
    chk("t4_words_mid", 64'(words_out), 64'd4);
    @(negedge clk);
    chk("t4_words_out", 64'(words_out), 64'd5);
    chk("t4_drained", 64'(out_valid), 64'd0);

    // fill then flush: pending run needs a second word
    step(128'h00001918171615, 7, 1, 5, "t5_taken_a");
    chk("t5_word_a", out_data,
        mkw(5, 0, g(0,0,21) | g(1,0,22) | g(2,0,23) | g(3,0,24) | g(4,0,25)));
    step(128'h0, 2, 1, 2, "t5_taken_b");
    chk("t5_word_b", out_data, mkw(1, 1, g(0,2,0)));
    @(negedge clk);
    chk("t5_words_out", 64'(words_out), 64'd7);

    // clear drops accumulated groups
    step(128'h0807, 2, 0, 2, "t6_taken_a");
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    step(128'h09, 1, 1, 1, "t6_taken_b");
    chk("t6_word", out_data, mkw(1, 0, g(0,0,9)));
    @(negedge clk);

    // asynchronous reset mid-word
    dir_ready = 1'b0;
    step(128'h0504030201, 5, 0, 5, "t7_taken_a");
    step(128'h0100, 2, 0, 2, "t7_taken_b");
    chk("t7_pre_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    in_count = 5'd16;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_out_valid", 64'(out_valid), 64'd0);
    chk("t7_out_data", out_data, 64'd0);
    chk("t7_words_out", 64'(words_out), 64'd0);
    chk("t7_in_taken", 64'(in_taken), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    dir_ready = 1'b1;
    @(negedge clk);
    step(128'h05, 1, 1, 1, "t7_taken_c");
    chk("t7_fresh_word", out_data, mkw(1, 0, g(0,0,5)));
    @(negedge clk);
    chk("t7_words_after", 64'(words_out), 64'd1);
    base = 1;

    // randomized segments against the model
    mon_en = 1'b1;
    for (int s = 0; s < 40; s++) begin
      seg.delete();
      len = (s % 7 == 3) ? 0 : int'($urandom_range(1, 48));
      for (int i = 0; i < len; i++)
        seg.push_back(($urandom_range(0, 9) < 6) ? 0
                      : int'($urandom_range(1, 255)));
      model_seg(seg);
      p = 0;
      done = 1'b0;
      budget = 0;
      while (!done) begin
        @(negedge clk);
        cnt = (len - p > 16) ? 16 : len - p;
        cnt = int'($urandom_range(0, cnt));
        if (len - p > 0 && cnt == 0 && $urandom_range(0, 1) == 1)
          cnt = 1;
        vld = ($urandom_range(0, 4) != 0);
        lst = (p + cnt == len);
        for (int l = 0; l < 16; l++)
          in_data[l*8 +: 8] = (l < cnt) ? 8'(seg[p+l]) : 8'($urandom);
        in_valid = vld;
        in_count = 5'(cnt);
        in_last  = lst;
        #1;
        tk = int'(in_taken);
        if (tk > cnt) chk("taken_le_count", 64'(tk), 64'(cnt));
        @(posedge clk);
        if (vld) begin
          p += tk;
          if (lst && tk == cnt) done = 1'b1;
        end
        budget++;
        if (budget > 3000) begin
          chk("seg_timeout", 64'(p), 64'(len));
          done = 1'b1;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int c = 0; c < 300 && (expq.size() != 0 || out_valid); c++)
      @(negedge clk);
    mon_en = 1'b0;
    chk("drain_empty", 64'(expq.size()), 64'd0);
    chk("rand_words_out", 64'(words_out), 64'(base + n_model));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
